// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RISC-V pipeline: operand forwarding,
// load-use / branch stall-flush control, memory wait-state freeze, watchdog and perf counters.
module pipeline_hazard_ctrl #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             Rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic             LoadE,
  input  logic [4:0]       RD_M,
  input  logic             RegWriteM,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             PCSrcF,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam int WCW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WCW-1:0] LIMIT = WCW'(WAIT_LIMIT);

  state_t           r_state;
  state_t           w_state_next;
  logic [WCW-1:0]   r_wait_cnt;
  logic [WCW-1:0]   w_wait_next;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_freeze;
  logic       w_load_use;
  logic       w_pcsrc_f;
  logic       w_stall_f;
  logic       w_stall_d;
  logic       w_stall_e;
  logic       w_stall_m;
  logic       w_flush_d;
  logic       w_flush_e;
  logic       w_flush_w;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // Memory stage result wins over Writeback; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RD_M != 5'd0) && (RD_M == rs))
      fwd_sel = 2'b10;
    else if (RegWriteW && (RD_W != 5'd0) && (RD_W == rs))
      fwd_sel = 2'b01;
    else
      fwd_sel = 2'b00;
  endfunction

  assign w_freeze   = MemReqM & ~MemReadyM;
  assign w_load_use = LoadE & (RD_E != 5'd0) & ((RD_E == RS1_D) | (RD_E == RS2_D));
  assign w_fwd_a    = fwd_sel(RS1_E);
  assign w_fwd_b    = fwd_sel(RS2_E);

  always_comb begin
    w_state_next = r_state;
    w_pcsrc_f    = 1'b0;
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_stall_e    = 1'b0;
    w_stall_m    = 1'b0;
    w_flush_d    = 1'b0;
    w_flush_e    = 1'b0;
    w_flush_w    = 1'b0;

    case (r_state)
      RUN:      if (w_freeze)  w_state_next = MEM_WAIT;
      MEM_WAIT: if (MemReadyM) w_state_next = RUN;
      default:  w_state_next = RUN;
    endcase

    // A branch seen while frozen stays in Execute and is applied on the release cycle.
    if (w_freeze) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
    end else if (PCSrcE) begin
      w_pcsrc_f = 1'b1;
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_load_use) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  always_comb begin
    w_wait_next = r_wait_cnt;
    if (w_freeze)
      w_wait_next = (r_wait_cnt == LIMIT) ? LIMIT : r_wait_cnt + 1'b1;
    else if (w_state_next == RUN)
      w_wait_next = '0;
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      if (w_wait_next == LIMIT)
        r_timeout <= 1'b1;
      if (w_stall_f && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_pcsrc_f && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // Combinational controls are held low for as long as reset is asserted.
  assign ForwardAE  = Rst ? w_fwd_a : 2'b00;
  assign ForwardBE  = Rst ? w_fwd_b : 2'b00;
  assign PCSrcF     = Rst & w_pcsrc_f;
  assign StallF     = Rst & w_stall_f;
  assign StallD     = Rst & w_stall_d;
  assign StallE     = Rst & w_stall_e;
  assign StallM     = Rst & w_stall_m;
  assign FlushD     = Rst & w_flush_d;
  assign FlushE     = Rst & w_flush_e;
  assign FlushW     = Rst & w_flush_w;
  assign MemTimeout = r_timeout;
  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected outputs are queued when a step is driven
// and popped for comparison at the following falling edge.
module tb_pipeline_hazard_ctrl;

  localparam int WAIT_LIMIT = 16;
  localparam int CNT_W      = 4;

  // control vector order: {PCSrcF, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_LU   = 8'b0110_0010;
  localparam logic [7:0] C_BR   = 8'b1000_0110;
  localparam logic [7:0] C_FRZ  = 8'b0111_1001;

  logic CLK = 1'b0;
  logic Rst;
  logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic PCSrcF, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [CNT_W-1:0] StallCount, FlushCount;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Rst(Rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
    .RD_E(RD_E), .LoadE(LoadE), .RD_M(RD_M), .RegWriteM(RegWriteM),
    .RD_W(RD_W), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .PCSrcF(PCSrcF),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  typedef struct {
    string            tag;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [7:0]       ctrl;
    logic             mto;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_sc = '0;
  logic [CNT_W-1:0] exp_fc = '0;
  logic [7:0] obs_ctrl;

  assign obs_ctrl = {PCSrcF, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  task automatic clear_inputs();
    RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    LoadE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [7:0] ctrl, input logic mto);
    exp_t e;
    exp_t o;
    e.tag = tag; e.fa = fa; e.fb = fb; e.ctrl = ctrl; e.mto = mto;
    e.sc = exp_sc; e.fc = exp_fc;
    sb.push_back(e);
    @(negedge CLK);
    o = sb.pop_front();
    checks++;
    assert (ForwardAE === o.fa) else begin
      errors++; $error("FAIL %s fwdA got %b want %b", o.tag, ForwardAE, o.fa);
    end
    checks++;
    assert (ForwardBE === o.fb) else begin
      errors++; $error("FAIL %s fwdB got %b want %b", o.tag, ForwardBE, o.fb);
    end
    checks++;
    assert (obs_ctrl === o.ctrl) else begin
      errors++; $error("FAIL %s ctrl got %b want %b", o.tag, obs_ctrl, o.ctrl);
    end
    checks++;
    assert (MemTimeout === o.mto) else begin
      errors++; $error("FAIL %s timeout got %b want %b", o.tag, MemTimeout, o.mto);
    end
    checks++;
    assert (StallCount === o.sc) else begin
      errors++; $error("FAIL %s stallcnt got %0d want %0d", o.tag, StallCount, o.sc);
    end
    checks++;
    assert (FlushCount === o.fc) else begin
      errors++; $error("FAIL %s flushcnt got %0d want %0d", o.tag, FlushCount, o.fc);
    end
    $display("step %-16s fa=%b fb=%b ctrl=%b mto=%b sc=%0d fc=%0d",
             o.tag, ForwardAE, ForwardBE, obs_ctrl, MemTimeout, StallCount, FlushCount);
    @(posedge CLK);
    #1;
    if (ctrl[6] && (exp_sc != '1)) exp_sc = exp_sc + 1'b1;
    if (ctrl[7] && (exp_fc != '1)) exp_fc = exp_fc + 1'b1;
  endtask

  initial begin
    clear_inputs();
    Rst = 1'b0;
    RegWriteM = 1; RD_M = 5; RS1_E = 5; MemReqM = 1; PCSrcE = 1;
    step("rst_gate", 2'b00, 2'b00, C_NONE, 1'b0);
    Rst = 1'b1;
    clear_inputs();

    // forwarding
    RegWriteM = 1; RD_M = 5; RS1_E = 5; RegWriteW = 1; RD_W = 5;
    step("fwd_mem_prio", 2'b10, 2'b00, C_NONE, 1'b0);
    RegWriteM = 0;
    step("fwd_wb", 2'b01, 2'b00, C_NONE, 1'b0);
    RegWriteM = 1; RD_M = 9; RS1_E = 3; RS2_E = 5;
    step("fwd_b_wb", 2'b00, 2'b01, C_NONE, 1'b0);
    RS1_E = 9;
    step("fwd_a_m_b_w", 2'b10, 2'b01, C_NONE, 1'b0);
    RD_M = 0; RS1_E = 0; RD_W = 0; RS2_E = 0;
    step("fwd_x0", 2'b00, 2'b00, C_NONE, 1'b0);
    clear_inputs();

    // load-use
    LoadE = 1; RD_E = 7; RS2_D = 7;
    step("load_use", 2'b00, 2'b00, C_LU, 1'b0);
    clear_inputs();
    step("load_moved", 2'b00, 2'b00, C_NONE, 1'b0);
    LoadE = 1; RD_E = 0; RS1_D = 0;
    step("load_rd_x0", 2'b00, 2'b00, C_NONE, 1'b0);
    LoadE = 1; RD_E = 7; RS1_D = 7; RS2_D = 2; PCSrcE = 1;
    step("branch_over_lu", 2'b00, 2'b00, C_BR, 1'b0);
    clear_inputs();
    step("after_branch", 2'b00, 2'b00, C_NONE, 1'b0);

    // three-cycle memory freeze
    MemReqM = 1; MemReadyM = 0; LoadE = 1; RD_E = 4; RS1_D = 4;
    for (int k = 0; k < 3; k++) step("freeze", 2'b00, 2'b00, C_FRZ, 1'b0);
    LoadE = 0; RD_E = 0; RS1_D = 0; MemReadyM = 1;
    step("freeze_release", 2'b00, 2'b00, C_NONE, 1'b0);
    clear_inputs();
    step("freeze_idle", 2'b00, 2'b00, C_NONE, 1'b0);

    // branch held across a two-cycle wait
    PCSrcE = 1; MemReqM = 1; MemReadyM = 0;
    for (int k = 0; k < 2; k++) step("br_frozen", 2'b00, 2'b00, C_FRZ, 1'b0);
    MemReadyM = 1;
    step("br_release", 2'b00, 2'b00, C_BR, 1'b0);
    clear_inputs();
    step("br_idle", 2'b00, 2'b00, C_NONE, 1'b0);

    // watchdog: flag becomes visible once WAIT_LIMIT frozen cycles have elapsed
    MemReqM = 1; MemReadyM = 0;
    for (int k = 1; k <= 20; k++)
      step("timeout_wait", 2'b00, 2'b00, C_FRZ, (k > WAIT_LIMIT));
    MemReadyM = 1;
    step("timeout_release", 2'b00, 2'b00, C_NONE, 1'b1);
    clear_inputs();
    step("timeout_sticky", 2'b00, 2'b00, C_NONE, 1'b1);

    // asynchronous reset in the middle of a wait
    MemReqM = 1; MemReadyM = 0;
    for (int k = 0; k < 2; k++) step("pre_rst_wait", 2'b00, 2'b00, C_FRZ, 1'b1);
    Rst = 1'b0;
    PCSrcE = 1; RegWriteW = 1; RD_W = 3; RS2_E = 3;
    exp_sc = '0; exp_fc = '0;
    step("async_rst", 2'b00, 2'b00, C_NONE, 1'b0);
    Rst = 1'b1;
    PCSrcE = 0; RegWriteW = 0;
    step("post_rst_wait", 2'b00, 2'b00, C_FRZ, 1'b0);
    MemReadyM = 1;
    step("post_rst_rel", 2'b00, 2'b00, C_NONE, 1'b0);
    clear_inputs();
    step("post_rst_idle", 2'b00, 2'b00, C_NONE, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
